// File: rtl/pc_gen_if.sv
// pc_gen_if: control/status bundle between the fetch-stage PC generator and
// its surrounding pipeline control. master drives the requests, slave is pc_gen.
interface pc_gen_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic              halt;
  logic              resume;
  logic              stall;
  logic              redir_valid;
  logic [ADDR_W-1:0] redir_target;
  logic              call;
  logic              ret;
  logic              exc_valid;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        state;
  logic [CNT_W-1:0]  cycles_counter;
  logic [CNT_W-1:0]  advance_counter;
  logic              ras_empty;
  logic              ras_full;
  logic              ras_err;

  modport master (
    output halt, resume, stall, redir_valid, redir_target, call, ret, exc_valid,
    input  pc, state, cycles_counter, advance_counter, ras_empty, ras_full, ras_err
  );

  modport slave (
    input  halt, resume, stall, redir_valid, redir_target, call, ret, exc_valid,
    output pc, state, cycles_counter, advance_counter, ras_empty, ras_full, ras_err
  );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: registered word-addressed fetch PC with run/halt control,
// prioritised halt > exception > redirect > return > stall > sequential,
// RUN-cycle and PC-advance counters.
// Optional feature macro PC_RAS_EN: circular return-address stack driven by
// call/ret. Without it call/ret are ignored and ras_* are constant.
//
// state      | meaning
// -----------+--------------------------------------------------
// ST_RESET   | out of reset, pc=RESET_VEC, moves to RUN next edge
// ST_RUN     | fetching, pc updated every cycle by priority rules
// ST_HALTED  | pc and counters frozen until resume or exception
// ST_ILLEGAL | unreachable encoding, recovers to RUN next edge
module pc_gen #(
  parameter int unsigned       ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'('h4),
  parameter logic [ADDR_W-1:0] STEP      = ADDR_W'(1),
  parameter int unsigned       CNT_W     = 32,
  parameter int unsigned       RAS_DEPTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  pc_gen_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RUN     = 2'd1,
    ST_HALTED  = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_t;

  state_t            state_q, state_next;
  logic [ADDR_W-1:0] pc_q, pc_next;
  logic [ADDR_W-1:0] seq_pc;
  logic [CNT_W-1:0]  cyc_q, adv_q;

  logic              push, pop, replace, err_set;
  logic              ras_call, ras_ret, ras_has;
  logic [ADDR_W-1:0] ras_top;

  assign seq_pc = pc_q + STEP;

`ifdef PC_RAS_EN
  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);

  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  wp_q;
  logic [PTR_W-1:0]  top_idx;
  logic [PTR_W:0]    cnt_q;
  logic              err_q;
  logic              full;

  assign ras_call = bus.call;
  assign ras_ret  = bus.ret;
  assign top_idx  = wp_q - PTR_W'(1);
  assign ras_has  = (cnt_q != '0);
  assign full     = (cnt_q == (PTR_W+1)'(RAS_DEPTH));
  assign ras_top  = ras_mem[top_idx];

  // Stack storage; validity lives in cnt_q, so entries need no reset.
  always_ff @(posedge clk) begin
    if (push)
      ras_mem[wp_q] <= seq_pc;
    else if (replace)
      ras_mem[top_idx] <= seq_pc;
  end

  // Write pointer, occupancy and sticky error; a push when full overwrites the oldest entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) begin
        wp_q <= wp_q + PTR_W'(1);
        if (!full)
          cnt_q <= cnt_q + (PTR_W+1)'(1);
      end else if (pop) begin
        wp_q  <= top_idx;
        cnt_q <= cnt_q - (PTR_W+1)'(1);
      end
      if (err_set || (push && full))
        err_q <= 1'b1;
    end
  end

  assign bus.ras_empty = ~ras_has;
  assign bus.ras_full  = full;
  assign bus.ras_err   = err_q;
`else
  logic unused_ras;

  assign ras_call      = 1'b0;
  assign ras_ret       = 1'b0;
  assign ras_has       = 1'b0;
  assign ras_top       = '0;
  assign unused_ras    = ^{bus.call, bus.ret, push, pop, replace, err_set, 1'(RAS_DEPTH)};
  assign bus.ras_empty = 1'b1;
  assign bus.ras_full  = 1'b0;
  assign bus.ras_err   = 1'b0;
`endif

  // Next-state / next-pc decision and stack operations for this cycle.
  always_comb begin
    state_next = state_q;
    pc_next    = pc_q;
    push       = 1'b0;
    pop        = 1'b0;
    replace    = 1'b0;
    err_set    = 1'b0;
    case (state_q)
      ST_RESET: state_next = ST_RUN;
      ST_RUN: begin
        if (bus.halt) begin
          state_next = ST_HALTED;
        end else if (bus.exc_valid) begin
          pc_next = EXC_VEC;
        end else if (bus.redir_valid) begin
          pc_next = bus.redir_target;
          // call+ret swaps the top for the new return address; empty stack degrades to a push
          if (ras_call) begin
            if (ras_ret && ras_has)
              replace = 1'b1;
            else
              push = 1'b1;
          end
        end else if (ras_ret) begin
          if (ras_has) begin
            pc_next = ras_top;
            pop     = 1'b1;
          end else begin
            pc_next = seq_pc;
            err_set = 1'b1;
          end
        end else if (!bus.stall) begin
          pc_next = seq_pc;
        end
      end
      ST_HALTED: begin
        if (bus.exc_valid) begin
          pc_next    = EXC_VEC;
          state_next = ST_RUN;
        end else if (bus.resume && !bus.halt) begin
          state_next = ST_RUN;
        end
      end
      default: state_next = ST_RUN;
    endcase
  end

  // PC and FSM state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_next;
      pc_q    <= pc_next;
    end
  end

  // RUN-cycle and PC-advance counters, frozen outside RUN, wrapping silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      adv_q <= '0;
    end else if (state_q == ST_RUN) begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (pc_next != pc_q)
        adv_q <= adv_q + CNT_W'(1);
    end
  end

  assign bus.pc              = pc_q;
  assign bus.state           = state_q;
  assign bus.cycles_counter  = cyc_q;
  assign bus.advance_counter = adv_q;

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors for pc_gen; covers the return stack when built with PC_RAS_EN.
module tb_pc_gen;

`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [31:0] m_pc;
  logic [1:0]  m_st;
  logic [31:0] m_cyc;
  logic [31:0] m_adv;

  pc_gen_if #(.ADDR_W(32), .CNT_W(32)) bus_if ();

  pc_gen #(.ADDR_W(32), .CNT_W(32), .RAS_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus_if.halt         = 1'b0;
    bus_if.resume       = 1'b0;
    bus_if.stall        = 1'b0;
    bus_if.redir_valid  = 1'b0;
    bus_if.redir_target = '0;
    bus_if.call         = 1'b0;
    bus_if.ret          = 1'b0;
    bus_if.exc_valid    = 1'b0;
  endtask

  // One clock with the inputs set up by the caller; counters expected from the bench's own pc/state history.
  task automatic step(input logic [31:0] epc, input logic [1:0] est);
    @(posedge clk);
    #1;
    clear_inputs();
    if (m_st == 2'd1) begin
      m_cyc = m_cyc + 1;
      if (epc != m_pc)
        m_adv = m_adv + 1;
    end
    m_pc = epc;
    m_st = est;
    check("pc", 64'(bus_if.pc), 64'(epc));
    check("state", 64'(bus_if.state), 64'(est));
    check("cycles", 64'(bus_if.cycles_counter), 64'(m_cyc));
    check("advance", 64'(bus_if.advance_counter), 64'(m_adv));
  endtask

  task automatic redir(input logic [31:0] tgt, input logic is_call);
    bus_if.redir_valid  = 1'b1;
    bus_if.redir_target = tgt;
    bus_if.call         = is_call;
  endtask

  task automatic check_ras(input string tag, input logic e, input logic f, input logic er);
    check({tag, "_empty"}, 64'(bus_if.ras_empty), 64'(e));
    check({tag, "_full"}, 64'(bus_if.ras_full), 64'(f));
    check({tag, "_err"}, 64'(bus_if.ras_err), 64'(er));
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    m_pc = '0; m_st = '0; m_cyc = '0; m_adv = '0;
    clear_inputs();
    rst_n = 1'b0;

    // reset state and release
    #12;
    check("rst_pc", 64'(bus_if.pc), 64'h0);
    check("rst_state", 64'(bus_if.state), 64'h0);
    check("rst_cycles", 64'(bus_if.cycles_counter), 64'h0);
    check("rst_advance", 64'(bus_if.advance_counter), 64'h0);
    check_ras("rst", 1'b1, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(32'h0, 2'd1);
    step(32'h1, 2'd1);
    step(32'h2, 2'd1);
    step(32'h3, 2'd1);
    check("idle_cycles", 64'(bus_if.cycles_counter), 64'd3);
    check("idle_advance", 64'(bus_if.advance_counter), 64'd3);

    // stall then redirect
    step(32'h4, 2'd1);
    step(32'h5, 2'd1);
    bus_if.stall = 1'b1; step(32'h5, 2'd1);
    bus_if.stall = 1'b1; step(32'h5, 2'd1);
    redir(32'h40, 1'b0);  step(32'h40, 2'd1);
    check("stall_cycles", 64'(bus_if.cycles_counter), 64'd8);
    check("stall_advance", 64'(bus_if.advance_counter), 64'd6);

    // two nested calls and two returns
    redir(32'h10, 1'b0);  step(32'h10, 2'd1);
    redir(32'h100, 1'b1); step(32'h100, 2'd1);
    check("call1_empty", 64'(bus_if.ras_empty), 64'(!RAS_ON));
    redir(32'h20, 1'b0);  step(32'h20, 2'd1);
    redir(32'h200, 1'b1); step(32'h200, 2'd1);
    bus_if.ret = 1'b1;    step(RAS_ON ? 32'h21 : 32'h201, 2'd1);
    bus_if.ret = 1'b1;    step(RAS_ON ? 32'h11 : 32'h202, 2'd1);
    check_ras("ret2", 1'b1, 1'b0, 1'b0);

`ifdef PC_RAS_EN
    // overflow a 4-deep stack, then drain it and underflow
    redir(32'h300, 1'b1); step(32'h300, 2'd1);
    redir(32'h400, 1'b1); step(32'h400, 2'd1);
    redir(32'h500, 1'b1); step(32'h500, 2'd1);
    redir(32'h600, 1'b1); step(32'h600, 2'd1);
    check_ras("push4", 1'b0, 1'b1, 1'b0);
    redir(32'h700, 1'b1); step(32'h700, 2'd1);
    check_ras("push5", 1'b0, 1'b1, 1'b1);
    bus_if.ret = 1'b1; step(32'h601, 2'd1);
    bus_if.ret = 1'b1; step(32'h501, 2'd1);
    bus_if.ret = 1'b1; step(32'h401, 2'd1);
    bus_if.ret = 1'b1; step(32'h301, 2'd1);
    check_ras("pop4", 1'b1, 1'b0, 1'b1);
    bus_if.ret = 1'b1; step(32'h302, 2'd1);
    check("underflow_err", 64'(bus_if.ras_err), 64'h1);

    // call+ret replaces the top entry
    redir(32'h800, 1'b1); step(32'h800, 2'd1);
    redir(32'h900, 1'b1); bus_if.ret = 1'b1; step(32'h900, 2'd1);
    check_ras("swap", 1'b0, 1'b0, 1'b1);
    bus_if.ret = 1'b1; step(32'h801, 2'd1);
    check("swap_pop_empty", 64'(bus_if.ras_empty), 64'h1);
`endif

    // pc wraps modulo 2^32
    redir(32'hFFFF_FFFF, 1'b0); step(32'hFFFF_FFFF, 2'd1);
    step(32'h0, 2'd1);

    // halt / resume / exception in HALTED
    redir(32'h7, 1'b0); step(32'h7, 2'd1);
    bus_if.halt = 1'b1; step(32'h7, 2'd2);
    step(32'h7, 2'd2);
    step(32'h7, 2'd2);
    bus_if.halt = 1'b1; bus_if.resume = 1'b1; step(32'h7, 2'd2);
    bus_if.resume = 1'b1; step(32'h7, 2'd1);
    step(32'h8, 2'd1);
    bus_if.halt = 1'b1; step(32'h8, 2'd2);
    bus_if.exc_valid = 1'b1; step(32'h4, 2'd1);
    step(32'h5, 2'd1);

    // asynchronous reset between edges
    #3;
    rst_n = 1'b0;
    #1;
    m_pc = '0; m_st = '0; m_cyc = '0; m_adv = '0;
    check("arst_pc", 64'(bus_if.pc), 64'h0);
    check("arst_state", 64'(bus_if.state), 64'h0);
    check("arst_cycles", 64'(bus_if.cycles_counter), 64'h0);
    check("arst_advance", 64'(bus_if.advance_counter), 64'h0);
    check_ras("arst", 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    step(32'h0, 2'd1);
    step(32'h1, 2'd1);
    check("post_rst_cycles", 64'(bus_if.cycles_counter), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
